// File: rtl/abacus_op_sched.sv
// rtl/abacus_op_sched.sv - round-robin scheduler feeding four button ops into one shared arithmetic unit
// Optional 8-bit WAIT watchdog compiled in when ABACUS_SCHED_TIMEOUT_EN is defined.
module abacus_op_sched (
    input  logic        clk,
    input  logic        clr_n,
    input  logic [3:0]  btn_req,
    input  logic [15:0] sw,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    output logic        alu_start,
    output logic [1:0]  alu_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [15:0] result,
    output logic [1:0]  result_op,
    output logic        result_valid,
    output logic        busy,
    output logic        err_div0,
    output logic        err_timeout
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t     state;
    logic [3:0] sync1, sync2, sync3;
    logic [3:0] pending, rise, grant_clr;
    logic [1:0] last_grant, grant;
    logic       grant_any;
`ifdef ABACUS_SCHED_TIMEOUT_EN
    logic [7:0] wd_cnt;
`else
    assign err_timeout = 1'b0;
`endif

    assign rise = sync2 & ~sync3;

    always_comb begin
        grant     = last_grant;
        grant_any = 1'b0;
        // Walk downward so the candidate nearest above last_grant is the one left standing.
        for (int k = 4; k >= 1; k--) begin
            if (pending[last_grant + 2'(k)]) begin
                grant     = last_grant + 2'(k);
                grant_any = 1'b1;
            end
        end
    end

    assign grant_clr = (state == IDLE && grant_any) ? (4'b0001 << grant) : 4'b0000;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sync1   <= 4'b0000;
            sync2   <= 4'b0000;
            sync3   <= 4'b0000;
            pending <= 4'b0000;
        end else begin
            sync1   <= btn_req;
            sync2   <= sync1;
            sync3   <= sync2;
            // A fresh press wins over the grant clearing the same bit.
            pending <= (pending & ~grant_clr) | rise;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state        <= IDLE;
            last_grant   <= 2'd3;
            alu_start    <= 1'b0;
            alu_op       <= 2'd0;
            alu_a        <= 8'h00;
            alu_b        <= 8'h00;
            result       <= 16'h0000;
            result_op    <= 2'd0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            err_div0     <= 1'b0;
`ifdef ABACUS_SCHED_TIMEOUT_EN
            err_timeout  <= 1'b0;
            wd_cnt       <= 8'h00;
`endif
        end else begin
            alu_start    <= 1'b0;
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        last_grant <= grant;
                        alu_op     <= grant;
                        alu_a      <= sw[15:8];
                        alu_b      <= sw[7:0];
                        busy       <= 1'b1;
                        if (grant[1] && sw[7:0] == 8'h00) begin
                            result    <= 16'h0000;
                            result_op <= grant;
                            err_div0  <= 1'b1;
`ifdef ABACUS_SCHED_TIMEOUT_EN
                            err_timeout <= 1'b0;
`endif
                            state     <= HOLD;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    alu_start <= 1'b1;
                    state     <= WAIT;
`ifdef ABACUS_SCHED_TIMEOUT_EN
                    wd_cnt    <= 8'h00;
`endif
                end
                WAIT: begin
                    if (alu_done) begin
                        result    <= alu_result;
                        result_op <= alu_op;
                        err_div0  <= 1'b0;
`ifdef ABACUS_SCHED_TIMEOUT_EN
                        err_timeout <= 1'b0;
`endif
                        state     <= HOLD;
                    end
`ifdef ABACUS_SCHED_TIMEOUT_EN
                    else if (wd_cnt == 8'hFF) begin
                        result      <= 16'hFFFF;
                        result_op   <= alu_op;
                        err_div0    <= 1'b0;
                        err_timeout <= 1'b1;
                        state       <= HOLD;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
`endif
                end
                HOLD: begin
                    result_valid <= 1'b1;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/abacus_op_sched.md
ABACUS_OP_SCHED -- requirements
Module: abacus_op_sched

Interface
REQ-001 SHALL have port clk  input  1  single system clock, rising-edge.
REQ-002 SHALL have port clr_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port btn_req  input  4  raw operation buttons: bit0 SUB, bit1 MUL, bit2 QUO, bit3 REM.
REQ-004 SHALL have port sw  input  16  operand switches: A = sw[15:8], B = sw[7:0].
REQ-005 SHALL have port alu_done  input  1  one-cycle completion pulse from shared arithmetic unit.
REQ-006 SHALL have port alu_result  input  16  unit result, valid with alu_done.
REQ-007 SHALL have ports alu_start (output, 1, one-cycle issue pulse), alu_op (output, 2, op code = btn_req bit index), alu_a and alu_b (output, 8 each, latched operands).
REQ-008 SHALL have ports result (output, 16), result_op (output, 2), result_valid (output, 1), busy (output, 1), err_div0 (output, 1), err_timeout (output, 1).

Function
REQ-009 SHALL pass each btn_req bit through a 2-flop synchronizer then rising-edge detect; a press sets pending[i] 3 cycles after the input rises.
REQ-010 SHALL merge repeated presses of an op already pending into one request.
REQ-011 SHALL, when a set and a grant-clear of the same pending bit coincide, leave the bit set.
REQ-012 SHALL implement states IDLE, ISSUE, WAIT, HOLD.
REQ-013 SHALL in IDLE with any pending bit grant one op round-robin, searching upward from (last_grant+1) mod 4; last_grant resets to 3 (SUB wins first).
REQ-014 SHALL on grant clear pending[grant], latch alu_a = sw[15:8], alu_b = sw[7:0], alu_op = grant, and go to ISSUE.
REQ-015 SHALL, if granted op is QUO or REM and latched B = 0, skip the unit: result = 16'h0000, err_div0 = 1, go to HOLD without any alu_start.
REQ-016 SHALL in ISSUE drive alu_start = 1 for exactly one cycle, then enter WAIT.
REQ-017 SHALL hold alu_op, alu_a, alu_b stable from ISSUE until leaving WAIT.
REQ-018 SHALL in WAIT, on alu_done, register result = alu_result, result_op = alu_op, clear both error flags, go to HOLD.
REQ-019 SHALL ignore alu_done outside WAIT.
REQ-020 SHALL in HOLD pulse result_valid for one cycle, then return to IDLE; result/result_op persist until next completion.
REQ-021 SHALL drive busy = 1 in ISSUE, WAIT, HOLD; 0 in IDLE.
REQ-022 SHALL accept new presses into pending in every state, including the op currently in flight (re-run after completion).
REQ-023 SHALL keep sw changes after grant from affecting the in-flight operation.
REQ-024 SHALL give minimum latency press-edge-to-alu_start of 5 cycles from idle (3 sync/pend + grant + ISSUE).

Reset
REQ-025 SHALL on clr_n = 0 asynchronously force state IDLE, pending = 0, last_grant = 3, timeout counter = 0, and all outputs 0.
REQ-026 SHALL, if reset asserts mid-WAIT, drop the operation; a later alu_done SHALL be ignored (state IDLE).
REQ-027 SHALL release from reset synchronously on the first clk edge after clr_n rises.

Configuration
REQ-028 SHALL compile an 8-bit WAIT watchdog only when macro ABACUS_SCHED_TIMEOUT_EN is defined.
REQ-029 SHALL with ABACUS_SCHED_TIMEOUT_EN: counter clears on entering WAIT, increments each WAIT cycle; at 255 without alu_done set err_timeout = 1, result = 16'hFFFF, result_op = alu_op, go to HOLD.
REQ-030 SHALL without ABACUS_SCHED_TIMEOUT_EN: wait indefinitely for alu_done; err_timeout tied 0.

Verification
REQ-031 SHALL cover: sw = 16'h0C03, press MUL, alu_done after 4 cycles with 16'h0024 -> one alu_start, alu_op = 1, alu_a = 8'h0C, alu_b = 8'h03, result = 16'h0024, result_valid single pulse.
REQ-032 SHALL cover: all four buttons rise same cycle -> grants SUB, MUL, QUO, REM in that order, exactly four alu_start pulses.
REQ-033 SHALL cover: sw = 16'h0900, press QUO -> no alu_start, err_div0 = 1, result = 0, result_valid pulse.
REQ-034 SHALL cover: press REM, change sw during WAIT, press REM again during WAIT -> alu_a/b unchanged in flight, second REM issued after HOLD with new sw.
REQ-035 SHALL cover: clr_n low mid-WAIT then alu_done -> outputs 0, no result_valid.
REQ-036 SHALL cover (macro defined): press SUB, never assert alu_done -> err_timeout = 1, result = 16'hFFFF 256 cycles after entering WAIT.
